// File: rtl/param_counter_if.sv
// rtl/param_counter_if.sv - control/status bundle for param_counter
//
// Purpose: groups the counter's control inputs and status outputs so that
// the counter and whatever drives it share one port.
// Signals:
//   en        count enable, one step per clk while high
//   up        direction: 1 = increment, 0 = decrement
//   load      synchronous load of load_val
//   load_val  value to load (clamped to MODULUS-1 by the counter)
//   clr       synchronous clear
//   count     current count (registered)
//   tc        one-cycle terminal-count pulse (registered)
//   ovf       sticky over/underflow flag (registered)
//   busy      high while the counter is in RUN
// Modports: master drives the controls, slave is the counter itself.
interface param_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             busy;

  modport master (
    output en, up, load, load_val, clr,
    input  count, tc, ovf, busy
  );

  modport slave (
    input  en, up, load, load_val, clr,
    output count, tc, ovf, busy
  );
endinterface

// File: rtl/param_counter.sv
// rtl/param_counter.sv - modulo up/down counter with IDLE/RUN/HOLD control FSM
//
// Purpose: counts 0..MODULUS-1 up or down, flags boundary events with a
// one-cycle tc pulse and a sticky ovf flag. Free-running builds wrap at the
// bound; ONESHOT builds stop at the bound and park in HOLD until clr/load.
// Optional feature macro: COUNTER_SAT_EN - with ONESHOT=0, saturate at the
// bound (count holds, state stays RUN, tc re-pulses on every further attempt)
// instead of wrapping.
// Parameters:
//   WIDTH    count width, 2..32
//   MODULUS  count range 0..MODULUS-1, 2..2**WIDTH
//   ONESHOT  0 = wrap (or saturate), 1 = stop at terminal value
// Ports:
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset; release synchronised internally
//   bus      param_counter_if slave modport (en, up, load, load_val, clr in;
//            count, tc, ovf, busy out)
module param_counter #(
  parameter int              WIDTH   = 8,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH,
  parameter bit              ONESHOT = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  param_counter_if.slave  bus
);

  // Highest legal count and the modulus held at WIDTH+1 bits so that
  // MODULUS = 2**WIDTH is representable for the top-of-range compare.
  localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             ovf_q;
  logic             busy_q;

  // Reset release flop: cleared asynchronously with rst_n, set on the first
  // clock edge after release. The state logic only acts once it is set, so
  // the first real operation lands on the second edge after release.
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Step datapath. The increment is formed at WIDTH+1 bits so reaching the
  // modulus is detected even when MODULUS = 2**WIDTH.
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH-1:0] dec_val;
  logic             at_top;
  logic             at_bottom;
  logic             boundary;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] load_clamped;

  always_comb begin
    inc_ext      = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    dec_val      = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
    at_top       = (inc_ext == MOD_EXT);
    at_bottom    = (count_q == '0);
    boundary     = bus.up ? at_top : at_bottom;
    step_val     = bus.up ? inc_ext[WIDTH-1:0] : dec_val;
    wrap_val     = bus.up ? '0 : TOP;
    load_clamped = (bus.load_val > TOP) ? TOP : bus.load_val;
  end

  // Control FSM with registered outputs. Priority per edge: clr, load, step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (armed) begin
      // tc is a single-cycle pulse; only a boundary step re-raises it.
      tc_q <= 1'b0;
      if (bus.clr) begin
        state   <= IDLE;
        count_q <= '0;
        ovf_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else if (bus.load) begin
        state   <= IDLE;
        count_q <= load_clamped;
        busy_q  <= 1'b0;
      end else begin
        case (state)
          IDLE, RUN: begin
            if (bus.en) begin
              if (boundary) begin
                tc_q  <= 1'b1;
                ovf_q <= 1'b1;
                if (ONESHOT) begin
                  // Park at the bound; count is left untouched.
                  state  <= HOLD;
                  busy_q <= 1'b0;
                end else begin
                  state  <= RUN;
                  busy_q <= 1'b1;
`ifdef COUNTER_SAT_EN
                  // Saturate: count stays at the bound while RUN continues,
                  // so every further attempt past it pulses tc again.
`else
                  count_q <= wrap_val;
`endif
                end
              end else begin
                state   <= RUN;
                busy_q  <= 1'b1;
                count_q <= step_val;
              end
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
          HOLD: begin
            // en and up are ignored; only clr, load or reset leave HOLD.
            busy_q <= 1'b0;
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.ovf   = ovf_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - scoreboard bench for param_counter (wrap and oneshot instances)
module tb_param_counter;

  localparam int W    = 4;
  localparam int MODI = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  param_counter_if #(.WIDTH(W)) bus0 ();
  param_counter_if #(.WIDTH(W)) bus1 ();

  param_counter #(.WIDTH(W), .MODULUS(64'd10), .ONESHOT(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  param_counter #(.WIDTH(W), .MODULUS(64'd10), .ONESHOT(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  typedef struct {
    int count;
    bit tc;
    bit ovf;
    bit busy;
    bit held;
    bit armed;
  } m_t;

  m_t   m0, m1, e0, e1;
  m_t   q0[$];
  m_t   q1[$];
  int   total = 0;
  int   bad   = 0;
  event sample_now;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference behaviour expressed as the rules of the counter: what the
  // observable outputs become after one clock edge (or under reset).
  function automatic m_t model(input m_t s, input bit rst, input bit en, input bit up,
                               input bit ld, input int lv, input bit cl, input bit os);
    m_t n;
    bit at_bound;
    n = s;
    if (!rst) begin
      n = '{default: 0};
      return n;
    end
    if (!s.armed) begin
      n.armed = 1'b1;
      return n;
    end
    n.tc = 1'b0;
    if (cl) begin
      n.count = 0; n.ovf = 0; n.busy = 0; n.held = 0;
    end else if (ld) begin
      n.count = (lv > MODI - 1) ? MODI - 1 : lv;
      n.busy  = 0; n.held = 0;
    end else if (s.held) begin
      n.busy = 0;
    end else if (!en) begin
      n.busy = 0;
    end else begin
      at_bound = up ? (s.count == MODI - 1) : (s.count == 0);
      if (!at_bound) begin
        n.count = up ? s.count + 1 : s.count - 1;
        n.busy  = 1;
      end else begin
        n.tc  = 1;
        n.ovf = 1;
        if (os) begin
          n.held = 1;
          n.busy = 0;
        end else begin
          n.busy = 1;
`ifndef COUNTER_SAT_EN
          n.count = (s.count + (up ? 1 : MODI - 1)) % MODI;
`endif
        end
      end
    end
    return n;
  endfunction

  bit cur_en, cur_up, cur_ld, cur_cl;
  int cur_lv;

  task automatic apply(input bit en, input bit up, input bit ld, input int lv, input bit cl);
    cur_en = en; cur_up = up; cur_ld = ld; cur_lv = lv; cur_cl = cl;
    bus0.en = en; bus0.up = up; bus0.load = ld; bus0.load_val = 4'(lv); bus0.clr = cl;
    bus1.en = en; bus1.up = up; bus1.load = ld; bus1.load_val = 4'(lv); bus1.clr = cl;
  endtask

  task automatic predict();
    m0 = model(m0, rst_n, cur_en, cur_up, cur_ld, cur_lv, cur_cl, 1'b0);
    m1 = model(m1, rst_n, cur_en, cur_up, cur_ld, cur_lv, cur_cl, 1'b1);
    q0.push_back(m0);
    q1.push_back(m1);
  endtask

  task automatic cycle(input bit en, input bit up, input bit ld, input int lv, input bit cl);
    @(negedge clk);
    apply(en, up, ld, lv, cl);
    predict();
  endtask

  // Assert reset between edges, check outputs with no clock, hold it across
  // one edge, release between edges.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    predict();
    -> sample_now;
    predict();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    predict();
  endtask

  // Monitor: every sample point pops the oldest expectation and compares.
  initial begin
    forever begin
      @(posedge clk or sample_now);
      #1;
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("wrap_count", int'(bus0.count), e0.count);
        chk("wrap_tc",    int'(bus0.tc),    int'(e0.tc));
        chk("wrap_ovf",   int'(bus0.ovf),   int'(e0.ovf));
        chk("wrap_busy",  int'(bus0.busy),  int'(e0.busy));
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("os_count", int'(bus1.count), e1.count);
        chk("os_tc",    int'(bus1.tc),    int'(e1.tc));
        chk("os_ovf",   int'(bus1.ovf),   int'(e1.ovf));
        chk("os_busy",  int'(bus1.busy),  int'(e1.busy));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    apply(0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b0;
    #2;
    predict();
    -> sample_now;
    @(negedge clk);
    rst_n = 1'b1;
    predict();

    // Free-running count through the wrap
    repeat (12) cycle(1, 1, 0, 0, 0);
    // Load clamps 13 to 9, then step past the top
    cycle(0, 1, 1, 13, 0);
    cycle(1, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    // clr wins over load
    cycle(0, 1, 1, 7, 0);
    cycle(0, 1, 1, 3, 1);
    // Underflow from 0: oneshot parks in HOLD, ignores en, exits on load
    cycle(0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    repeat (5) cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 4, 0);
    cycle(1, 1, 0, 0, 0);
    // Asynchronous reset mid-count, stepping resumes on the second edge
    cycle(0, 1, 1, 6, 0);
    async_reset();
    repeat (3) cycle(1, 1, 0, 0, 0);
    // Direction toggling every cycle from 5
    cycle(0, 1, 1, 5, 0);
    for (int i = 0; i < 4; i++) cycle(1, (i % 2) == 0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        cycle($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < 6, int'($urandom_range(0, 15)),
              $urandom_range(0, 99) < 3);
      end
    end

    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 Parameter WIDTH, default 8: count register width in bits, legal range 2..32.
REQ-002 Parameter MODULUS, default 2**WIDTH: count range is 0..MODULUS-1; legal range 2..2**WIDTH.
REQ-003 Parameter ONESHOT, default 0: 0 = free-running (wraps), 1 = stops at terminal value.
REQ-004 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port en  input  1  count enable; one step per clk while high.
REQ-007 Port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 Port load  input  1  synchronous load of load_val.
REQ-009 Port load_val  input  WIDTH  value to load.
REQ-010 Port clr  input  1  synchronous clear.
REQ-011 Port count  output  WIDTH  current count, registered.
REQ-012 Port tc  output  1  registered terminal-count pulse, high for exactly one cycle per boundary event.
REQ-013 Port ovf  output  1  sticky over/underflow flag, registered.
REQ-014 Port busy  output  1  high while the FSM is in RUN.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, HOLD.
REQ-016 Per-edge priority SHALL be: clr, then load, then count step.
REQ-017 clr SHALL set count=0, tc=0, ovf=0 and state=IDLE, from any state.
REQ-018 load SHALL set count=min(load_val, MODULUS-1) and state=IDLE, from any state; tc=0; ovf is unchanged.
REQ-019 In IDLE with en=1, the block SHALL take one step on that edge and enter RUN.
REQ-020 In RUN with en=0, the block SHALL enter IDLE with count held.
REQ-021 Step up from MODULUS-1, or down from 0, is a boundary event; every other step SHALL change count by exactly +/-1.
REQ-022 On a boundary event with ONESHOT=0, count SHALL wrap (MODULUS-1->0, or 0->MODULUS-1), tc=1 for the next cycle, ovf=1, state stays RUN.
REQ-023 On a boundary event with ONESHOT=1, count SHALL hold at the bound, tc=1 for one cycle, ovf=1, state->HOLD.
REQ-024 In HOLD, en and up SHALL be ignored and count held; only clr, load or reset exit HOLD.
REQ-025 tc SHALL be 0 on every edge that is not a boundary event.
REQ-026 Direction change mid-run SHALL take effect on the same edge; no idle cycle.
REQ-027 The next count SHALL be computed at WIDTH+1 bits so that MODULUS=2**WIDTH wraps correctly.

Reset
REQ-028 rst_n=0 SHALL immediately force count=0, tc=0, ovf=0, busy=0 and state=IDLE, with no clock required.
REQ-029 Deassertion of rst_n SHALL be synchronised internally, taking effect on the second rising clk edge after deassertion.
REQ-030 Reset asserted mid-count or in HOLD SHALL discard all state; no count value survives reset.

Configuration
REQ-031 Macro COUNTER_SAT_EN: when defined and ONESHOT=0, a boundary event SHALL saturate: count holds at the bound, tc pulses and ovf sets, state stays RUN, and tc re-pulses on every further step attempted past the bound.
REQ-032 Without COUNTER_SAT_EN, the wrap behaviour of REQ-022 SHALL apply; with ONESHOT=1, REQ-023 SHALL apply regardless of the macro.

Verification
(All scenarios use WIDTH=4 and MODULUS=10.)
REQ-033 Reset then en=1, up=1 for 12 cycles -> count 1..9, 0, 1, 2; tc high only in the cycle after 9->0; ovf=1 from that edge onward.
REQ-034 load=1 with load_val=13 -> count=9; then one up step -> count=0 and tc=1 (wrap build), or count=9 and tc=1 (COUNTER_SAT_EN build).
REQ-035 ONESHOT=1, count=0, en=1, up=0 -> count stays 0, tc pulses once, busy=0, state HOLD; en held high for 5 more cycles -> no change; load_val=4 with load -> count=4, state IDLE.
REQ-036 clr and load asserted on the same edge with count=7 -> count=0, ovf=0, state IDLE.
REQ-037 rst_n pulled low between clock edges at count=6 -> count=0 immediately, without a clock; first step occurs on the second edge after release.
REQ-038 Toggle up every cycle with en=1, starting from count=5 -> count alternates 6, 5, 6, 5; tc stays 0.
